// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, miss/redirect handling and decoded register addresses.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        data_hazard,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [4:0]  a0,
  output logic [4:0]  a1,
  output logic [4:0]  a2,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {RUN, MISS, REDIRECT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] instr_pc_reg;
  logic        instr_valid_reg;

  logic hold, redirect, accept, miss;
  logic jt_low_unused;

  assign hold          = stall | data_hazard;
  // A stalled pipeline cannot take the redirect; execute keeps jump_taken asserted.
  assign redirect      = jump_taken & ~stall;
  assign accept        = imem_req & imem_ready & ~hold & ~jump_taken;
  assign miss          = imem_req & ~imem_ready & ~hold & ~jump_taken;
  assign jt_low_unused = ^jump_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = REDIRECT;
    end else if (!hold) begin
      case (state_reg)
        REDIRECT: state_next = RUN;
        default:  state_next = imem_ready ? RUN : MISS;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state_reg != REDIRECT);
    imem_addr = pc_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      instr_reg       <= NOP;
      instr_pc_reg    <= RESET_PC;
      instr_valid_reg <= 1'b0;
    end else if (redirect) begin
      pc_reg          <= {jump_target[31:2], 2'b00};
      instr_valid_reg <= 1'b0;
    end else if (accept) begin
      instr_reg       <= imem_rdata;
      instr_pc_reg    <= pc_reg;
      instr_valid_reg <= 1'b1;
      pc_reg          <= pc_reg + 32'd4;
    end else if (miss) begin
      instr_valid_reg <= 1'b0;
    end
  end

  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;

  // Branches and stores have no destination register, so a2 is suppressed for them.
  always_comb begin
    a0 = 5'd0;
    a1 = 5'd0;
    a2 = 5'd0;
    if (instr_valid_reg) begin
      a0 = instr_reg[19:15];
      a1 = instr_reg[24:20];
      if (instr_reg[6:0] != 7'b1100011 && instr_reg[6:0] != 7'b0100011)
        a2 = instr_reg[11:7];
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_reg, miss_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_reg <= 32'd0;
      miss_count_reg  <= 32'd0;
    end else begin
      if (accept)                  fetch_count_reg <= fetch_count_reg + 32'd1;
      if (imem_req && !imem_ready) miss_count_reg  <= miss_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
  assign miss_count  = miss_count_reg;
`else
  assign fetch_count = 32'd0;
  assign miss_count  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded random/directed bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, data_hazard = 1'b0, jump_taken = 1'b0, imem_ready = 1'b0;
  logic [31:0] jump_target = 32'd0, imem_rdata = 32'd0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc, fetch_count, miss_count;
  logic [4:0]  a0, a1, a2;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .data_hazard(data_hazard),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .a0(a0), .a1(a1), .a2(a2),
    .fetch_count(fetch_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic [31:0] addr;
    logic        req;
    logic [4:0]  r1, r2, rd;
    logic [31:0] fc, mc;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  // Behavioural model: fetch position, last delivered instruction, and a redirect bubble flag.
  logic [31:0] m_pc, m_ins, m_ipc, m_fc, m_mc;
  logic        m_valid, m_redir;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] v;
    v = a * 32'h9E37_79B1 + 32'h0123_4567;
    if (a == 32'h14) return 32'h0020_8133;
    if (a == 32'h18) return 32'h0020_8463;
    case (a[5:4])
      2'd0:    return {v[31:7], 7'b1100011};
      2'd1:    return {v[31:7], 7'b0100011};
      default: return v;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_ins = 32'h13; m_ipc = RESET_PC; m_valid = 1'b0;
    m_redir = 1'b0; m_fc = 0; m_mc = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.valid = m_valid; e.ipc = m_ipc; e.ins = m_ins; e.addr = m_pc; e.req = !m_redir;
    e.r1 = m_valid ? m_ins[19:15] : 5'd0;
    e.r2 = m_valid ? m_ins[24:20] : 5'd0;
    e.rd = (m_valid && m_ins[6:0] != 7'b1100011 && m_ins[6:0] != 7'b0100011) ? m_ins[11:7] : 5'd0;
`ifdef FETCH_PERF_EN
    e.fc = m_fc; e.mc = m_mc;
`else
    e.fc = 0; e.mc = 0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven at the falling edge; expected post-edge view is queued.
  task automatic step(input logic s, input logic dh, input logic jt,
                      input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    stall = s; data_hazard = dh; jump_taken = jt; jump_target = tgt; imem_ready = rdy;
    imem_rdata = rdy ? mem(m_pc) : 32'hDEAD_BEEF;
    if (!m_redir && !rdy) m_mc++;
    if (jt && !s) begin
      m_pc = {tgt[31:2], 2'b00}; m_valid = 1'b0; m_redir = 1'b1;
    end else if (s || dh) begin
      // frozen
    end else if (m_redir) begin
      m_redir = 1'b0;
    end else if (rdy) begin
      m_ins = mem(m_pc); m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_fc++;
    end else begin
      m_valid = 1'b0;
    end
    q.push_back(model_out());
  endtask

  // Monitor: every output snapshot taken just after the active edge is matched against the queue.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
      if (e.valid) begin
        check("instr", instr, e.ins);
        check("instr_pc", instr_pc, e.ipc);
      end
      check("imem_addr", imem_addr, e.addr);
      check("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      check("a0", {27'd0, a0}, {27'd0, e.r1});
      check("a1", {27'd0, a1}, {27'd0, e.r2});
      check("a2", {27'd0, a2}, {27'd0, e.rd});
      check("fetch_count", fetch_count, e.fc);
      check("miss_count", miss_count, e.mc);
    end
  end

  task automatic check_reset_view(input string tag);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'h13);
    check({tag, "_instr_pc"}, instr_pc, RESET_PC);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_fc"}, fetch_count, 32'd0);
    check({tag, "_mc"}, miss_count, 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_view("reset");
    @(negedge clk); rst = 1'b0;

    // Sequential fetch 0,4,8,0xC then a three-cycle miss at 0x10.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    // 0x14 holds an R-type add; freeze it with a two-cycle hazard.
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);               // 0x18 branch: a2 must read 0
    // Redirect with misaligned target while rdata is live.
    step(0, 0, 1, 32'h103, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Jump held under stall for two cycles, taken on release.
    step(1, 0, 1, 32'h40, 1);
    step(1, 0, 1, 32'h40, 1);
    step(0, 0, 1, 32'h40, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      logic s, dh, jt, rdy;
      s   = ($urandom_range(0, 9) == 0);
      dh  = ($urandom_range(0, 9) == 0);
      jt  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(s, dh, jt, $urandom & 32'h0000_03FF, rdy);
    end

    // Reset asserted in the middle of a miss must abandon it.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_view("midmiss_reset");
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    model_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
